// File: rtl/db_pkg.sv
// db_pkg: shared types and constants for the db_bank debouncer.
//   db_state_t  - per-channel debounce state (2-bit)
//   width_for() - counter width able to hold 0..max_val
//   DEF_*       - default parameter values
package db_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    W1 = 2'd1,
    S1 = 2'd2,
    W0 = 2'd3
  } db_state_t;

  localparam int DEF_CHANNELS     = 4;
  localparam int DEF_TICK_DIV     = 500000;
  localparam int DEF_STABLE_TICKS = 3;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_LONG_TICKS   = 100;

  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEF_CNT_W  = width_for(DEF_STABLE_TICKS);
  localparam int DEF_HOLD_W = width_for(DEF_LONG_TICKS);

endpackage

// File: rtl/db_channel.sv
// db_channel: one debounce channel.
//   Synchroniser -> symmetric debounce FSM -> registered db and edge pulses.
//   Optional hold counter / long_press when DB_LONG_PRESS_EN is defined.
// Ports:
//   clk, reset   clock, async active-high reset
//   tick         shared sample tick (one clk wide)
//   mask         1 = channel enabled; 0 forces stable-low
//   raw          asynchronous raw level
//   db           debounced level
//   rise, fall   one-clk pulses, the cycle after db changes
//   long_press   one-clk pulse after LONG_TICKS ticks of db high (DB_LONG_PRESS_EN)
//
// state | meaning
// S0    | stable low, db = 0
// W1    | input high, counting ticks before committing high, db = 0
// S1    | stable high, db = 1
// W0    | input low, counting ticks before committing low, db = 1
module db_channel
  import db_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
`ifdef DB_LONG_PRESS_EN
  , parameter int LONG_TICKS = DEF_LONG_TICKS
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic mask,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
`ifdef DB_LONG_PRESS_EN
  , output logic long_press
`endif
);

  localparam int CW = width_for(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_in;
  db_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d1_q, rise_q, fall_q;

  assign s_in = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A level change on s_in always takes priority over a coincident tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mask) begin
      state_d = S0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S0: if (s_in) begin
          state_d = W1;
          cnt_d   = '0;
        end
        W1: begin
          if (!s_in) state_d = S0;
          else if (tick) begin
            if (cnt_q == CNT_LAST) state_d = S1;
            else                   cnt_d   = cnt_q + CW'(1);
          end
        end
        S1: if (!s_in) begin
          state_d = W0;
          cnt_d   = '0;
        end
        W0: begin
          if (s_in) state_d = S1;
          else if (tick) begin
            if (cnt_q == CNT_LAST) state_d = S0;
            else                   cnt_d   = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // db tracks the state register; pulses compare db against its one-cycle delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q    <= 1'b0;
      db_d1_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      db_q    <= (state_d == S1) || (state_d == W0);
      db_d1_q <= db_q;
      rise_q  <= db_q & ~db_d1_q;
      fall_q  <= ~db_q & db_d1_q;
    end
  end

  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef DB_LONG_PRESS_EN
  localparam int HW = width_for(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

  logic [HW-1:0] hold_q;
  logic          lp_q;

  // Saturation at HOLD_MAX is what limits long_press to once per press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      lp_q   <= 1'b0;
    end else begin
      lp_q <= 1'b0;
      if (!db_q) begin
        hold_q <= '0;
      end else if (tick && (hold_q != HOLD_MAX)) begin
        hold_q <= hold_q + HW'(1);
        if (hold_q == HOLD_LAST) lp_q <= mask;
      end
    end
  end

  assign long_press = lp_q;
`endif

endmodule

// File: rtl/db_bank.sv
// db_bank: multi-channel button/switch debouncer.
//   Shared prescaler generates tick; CHANNELS independent db_channel instances.
//   Optional feature macro: DB_LONG_PRESS_EN (adds long_press port and hold counters).
// Ports:
//   clk, reset   clock, async active-high reset
//   raw_in       raw asynchronous levels, one per channel
//   ch_mask      1 = channel enabled
//   db           debounced levels
//   rise, fall   one-clk edge pulses per channel
//   tick         prescaler tick, high while the prescaler sits at TICK_DIV-1
//   long_press   one-clk long-press pulses (DB_LONG_PRESS_EN only)
module db_bank
  import db_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CHANNELS-1:0] ch_mask,
  output logic [CHANNELS-1:0] db,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                tick
`ifdef DB_LONG_PRESS_EN
  , output logic [CHANNELS-1:0] long_press
`endif
);

  if (CHANNELS < 1 || CHANNELS > 32 || TICK_DIV < 2 ||
      STABLE_TICKS < 1 || STABLE_TICKS > 15 ||
      SYNC_STAGES < 2 || SYNC_STAGES > 3 || LONG_TICKS < 1) begin : g_bad_params
    $error("db_bank: parameter out of range");
  end

  localparam int DW = width_for(TICK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick_q;

  assign div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);

  // tick is registered from the next count so it is high exactly while div_q == DIV_LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= (div_d == DIV_LAST);
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    db_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .SYNC_STAGES (SYNC_STAGES)
`ifdef DB_LONG_PRESS_EN
      , .LONG_TICKS(LONG_TICKS)
`endif
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .tick (tick_q),
      .mask (ch_mask[i]),
      .raw  (raw_in[i]),
      .db   (db[i]),
      .rise (rise[i]),
      .fall (fall[i])
`ifdef DB_LONG_PRESS_EN
      , .long_press(long_press[i])
`endif
    );
  end

endmodule

// File: tb/tb_db_bank.sv
// tb_db_bank: self-checking bench for db_bank (CHANNELS=4, TICK_DIV=4,
// STABLE_TICKS=3, SYNC_STAGES=2, LONG_TICKS=5). Define DB_LONG_PRESS_EN to
// also exercise long_press.
module tb_db_bank;

  localparam int CH = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int SS = 2;
  localparam int LT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] raw_in, ch_mask;
  logic [CH-1:0] db, rise, fall;
  logic          tick;
`ifdef DB_LONG_PRESS_EN
  logic [CH-1:0] long_press;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  db_bank #(
    .CHANNELS(CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .SYNC_STAGES(SS), .LONG_TICKS(LT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw_in (raw_in),
    .ch_mask(ch_mask),
    .db     (db),
    .rise   (rise),
    .fall   (fall),
    .tick   (tick)
`ifdef DB_LONG_PRESS_EN
    , .long_press(long_press)
`endif
  );

  // Reference model: input seen two edges late, debounced level flips after
  // ST ticks counted during an unbroken run of input != db (the first cycle
  // of a run only notices the change), pulses appear one cycle after db moves.
  bit [CH-1:0] m_db, m_db_prev, m_rise, m_fall, m_lp, d1, d2, run;
  bit          m_tick;
  int          edges;
  int          nt[CH];
  int          hold[CH];

  function automatic void model_reset();
    m_db = '0; m_db_prev = '0; m_rise = '0; m_fall = '0; m_lp = '0;
    d1 = '0; d2 = '0; run = '0; m_tick = 1'b0; edges = 0;
    for (int c = 0; c < CH; c++) begin
      nt[c] = 0;
      hold[c] = 0;
    end
  endfunction

  function automatic void model_edge(input bit [CH-1:0] rv, input bit [CH-1:0] mv);
    bit          tick_now;
    bit [CH-1:0] s, db_pre;
    tick_now = m_tick;
    s = d2;
    db_pre = m_db;
    m_rise = m_db & ~m_db_prev;
    m_fall = ~m_db & m_db_prev;
    m_db_prev = m_db;
    for (int c = 0; c < CH; c++) begin
      if (!mv[c]) begin
        m_db[c] = 1'b0; run[c] = 1'b0; nt[c] = 0;
      end else if (s[c] != m_db[c]) begin
        if (!run[c]) begin
          run[c] = 1'b1; nt[c] = 0;
        end else if (tick_now) begin
          nt[c]++;
          if (nt[c] == ST) begin
            m_db[c] = s[c]; run[c] = 1'b0;
          end
        end
      end else begin
        run[c] = 1'b0;
      end
      m_lp[c] = 1'b0;
      if (!db_pre[c]) hold[c] = 0;
      else if (tick_now && hold[c] < LT) begin
        hold[c]++;
        if (hold[c] == LT && mv[c]) m_lp[c] = 1'b1;
      end
    end
    d2 = d1;
    d1 = rv;
    edges++;
    m_tick = ((edges % TD) == TD - 1);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge(raw_in, ch_mask);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    int first_tick;
    raw_in = '1; ch_mask = '1;
    settle(20);
    n_tests++;
    if (db !== 4'hF) begin
      n_fail++; $display("FAIL pre_reset_db: got %b expected 1111", db);
    end
    @(posedge clk); #3; reset = 1'b1; #1;
    n_tests++;
    if ({db, rise, fall, tick} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_async: got db=%b rise=%b fall=%b tick=%b expected all 0", db, rise, fall, tick);
    end
    model_reset();
    @(posedge clk); #2; raw_in = '0; reset = 1'b0;
    first_tick = -1;
    for (int i = 1; i <= 13; i++) begin
      step();
      if (tick && first_tick < 0) first_tick = i;
      n_tests++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("FAIL reset_release cyc %0d: got db=%b rise=%b fall=%b tick=%b expected %b %b %b %b",
                 i, db, rise, fall, tick, m_db, m_rise, m_fall, m_tick);
      end
    end
    n_tests++;
    if (first_tick != TD - 1) begin
      n_fail++; $display("FAIL first_tick: got edge %0d expected edge %0d", first_tick, TD - 1);
    end
  endtask

  task automatic test_clean_press();
    int lat, rises;
    raw_in = '0; ch_mask = '1;
    settle(20);
    raw_in[0] = 1'b1;
    lat = -1; rises = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (db[0] && lat < 0) lat = i;
      if (rise[0]) rises++;
      n_tests++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick} || db[3:1] !== 3'b000) begin
        n_fail++;
        $display("FAIL press cyc %0d: got db=%b rise=%b fall=%b tick=%b expected %b %b %b %b",
                 i, db, rise, fall, tick, m_db, m_rise, m_fall, m_tick);
      end
    end
    n_tests++;
    if (lat < 11 || lat > 15) begin
      n_fail++; $display("FAIL press_latency: got %0d clks expected 11..15", lat);
    end
    n_tests++;
    if (rises != 1) begin
      n_fail++; $display("FAIL press_rise_count: got %0d expected 1", rises);
    end
  endtask

  task automatic test_glitch();
    int bad;
    raw_in = '0; ch_mask = '1;
    settle(20);
    bad = 0;
    for (int i = 0; i < 36; i++) begin
      raw_in[1] = (i < 6);
      step();
      if (db[1] || rise[1]) bad++;
      n_tests++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("FAIL glitch cyc %0d: got db=%b rise=%b fall=%b expected %b %b %b",
                 i, db, rise, fall, m_db, m_rise, m_fall);
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL glitch_reject: got %0d cycles with db1/rise1 high expected 0", bad);
    end
  endtask

  task automatic test_bounce();
    int falls, low_bounce, lat;
    raw_in = 4'b0100; ch_mask = '1;
    settle(25);
    falls = 0; low_bounce = 0;
    for (int k = 0; k < 24; k++) begin
      if (k % 3 == 0) raw_in[2] = ~raw_in[2];
      step();
      if (!db[2]) low_bounce++;
      if (fall[2]) falls++;
      n_tests++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("FAIL bounce cyc %0d: got db=%b rise=%b fall=%b expected %b %b %b",
                 k, db, rise, fall, m_db, m_rise, m_fall);
      end
    end
    raw_in[2] = 1'b0;
    lat = -1;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (!db[2] && lat < 0) lat = i;
      if (fall[2]) falls++;
      n_tests++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("FAIL release cyc %0d: got db=%b rise=%b fall=%b expected %b %b %b",
                 i, db, rise, fall, m_db, m_rise, m_fall);
      end
    end
    n_tests++;
    if (low_bounce != 0) begin
      n_fail++; $display("FAIL bounce_hold: got db2 low %0d cycles expected 0", low_bounce);
    end
    n_tests++;
    if (lat < 11 || lat > 15) begin
      n_fail++; $display("FAIL release_latency: got %0d clks expected 11..15", lat);
    end
    n_tests++;
    if (falls != 1) begin
      n_fail++; $display("FAIL release_fall_count: got %0d expected 1", falls);
    end
  endtask

  task automatic test_mask_reset();
    int falls, rises, pulses;
    raw_in = 4'b1000; ch_mask = '1;
    settle(25);
    n_tests++;
    if (db[3] !== 1'b1) begin
      n_fail++; $display("FAIL mask_pre_db: got %b expected 1", db[3]);
    end
    ch_mask[3] = 1'b0;
    step();
    n_tests++;
    if (db[3] !== 1'b0) begin
      n_fail++; $display("FAIL mask_db_next: got %b expected 0", db[3]);
    end
    falls = fall[3]; rises = rise[3];
    for (int i = 0; i < 8; i++) begin
      step();
      falls += fall[3]; rises += rise[3];
      n_tests++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("FAIL masked cyc %0d: got db=%b rise=%b fall=%b expected %b %b %b",
                 i, db, rise, fall, m_db, m_rise, m_fall);
      end
    end
    n_tests++;
    if (falls != 1 || rises != 0) begin
      n_fail++; $display("FAIL mask_pulses: got fall=%0d rise=%0d expected fall=1 rise=0", falls, rises);
    end
    ch_mask[3] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_tests++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("FAIL unmask cyc %0d: got db=%b rise=%b fall=%b expected %b %b %b",
                 i, db, rise, fall, m_db, m_rise, m_fall);
      end
    end
    raw_in = '0;
    settle(25);
    raw_in[1] = 1'b1;
    settle(5);
    @(posedge clk); #3; reset = 1'b1; #1;
    n_tests++;
    if ({db, rise, fall} !== 12'd0) begin
      n_fail++; $display("FAIL reset_w1: got db=%b rise=%b fall=%b expected all 0", db, rise, fall);
    end
    model_reset();
    @(posedge clk); #2; raw_in = '0; reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      pulses += $countones(rise | fall | db);
      n_tests++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("FAIL post_reset cyc %0d: got db=%b rise=%b fall=%b tick=%b expected %b %b %b %b",
                 i, db, rise, fall, tick, m_db, m_rise, m_fall, m_tick);
      end
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL reset_no_pulse: got %0d active bits expected 0", pulses);
    end
  endtask

`ifdef DB_LONG_PRESS_EN
  task automatic test_long_press();
    int t_db, t_lp, n_lp;
    raw_in = '0; ch_mask = '1;
    settle(25);
    raw_in[0] = 1'b1;
    t_db = -1; t_lp = -1; n_lp = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (db[0] && t_db < 0) t_db = i;
      if (long_press[0]) begin
        n_lp++;
        if (t_lp < 0) t_lp = i;
      end
      n_tests++;
      if ({db, rise, fall, long_press} !== {m_db, m_rise, m_fall, m_lp}) begin
        n_fail++;
        $display("FAIL long cyc %0d: got db=%b rise=%b fall=%b lp=%b expected %b %b %b %b",
                 i, db, rise, fall, long_press, m_db, m_rise, m_fall, m_lp);
      end
    end
    n_tests++;
    if (n_lp != 1) begin
      n_fail++; $display("FAIL long_count: got %0d expected 1", n_lp);
    end
    n_tests++;
    if (t_lp - t_db != LT * TD) begin
      n_fail++; $display("FAIL long_delay: got %0d clks expected %0d", t_lp - t_db, LT * TD);
    end
  endtask
`endif

  task automatic test_random();
    raw_in = '0; ch_mask = '1;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 9) == 0)  raw_in[c]  = ~raw_in[c];
        if ($urandom_range(0, 79) == 0) ch_mask[c] = ~ch_mask[c];
      end
      if (i % 150 == 0) raw_in = 4'($urandom);
      step();
      n_tests++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got db=%b rise=%b fall=%b tick=%b expected %b %b %b %b",
                 i, db, rise, fall, tick, m_db, m_rise, m_fall, m_tick);
      end
`ifdef DB_LONG_PRESS_EN
      n_tests++;
      if (long_press !== m_lp) begin
        n_fail++; $display("FAIL random_lp cyc %0d: got %b expected %b", i, long_press, m_lp);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; raw_in = '0; ch_mask = '1;
    model_reset();
    #22 reset = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_mask_reset();
`ifdef DB_LONG_PRESS_EN
    test_long_press();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
